// File: rtl/speed_pkg.sv
// speed_pkg: shared types and default constants for the wheel speed unit.
//   state_e        - speed request FSM states
//   DEF_CONST      - Q8.8 unit-conversion constant (~73.728)
//   DEF_FRAC       - fractional bits of DEF_CONST dropped before division
//   DEF_MAX_SPEED  - saturation value for the reported speed
//   DEF_TIMEOUT    - tick count after which the wheel is declared stopped
package speed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_RES,
        SHORT,
        SAT,
        DONE
    } state_e;

    localparam logic [15:0] DEF_CONST     = 16'h49BA;
    localparam int          DEF_FRAC      = 8;
    localparam int          DEF_MAX_SPEED = 99;
    localparam int          DEF_TIMEOUT   = 4000;

endpackage

// File: rtl/speed_period_meter.sv
// speed_period_meter: measures the wheel revolution period in timebase ticks.
//   clk, rst   - system clock, asynchronous active-high reset
//   en_i       - timebase tick enable, counter advances only when high
//   reed_i     - synchronised reed contact level
//   period_o   - latest revolution period (or 4-period average)
//   stopped_o  - wheel stopped / no full revolution measured yet
// Build option SPEED_AVG4_EN: period_o is the average of the last four
// periods and stopped_o stays high until four periods have been collected.
module speed_period_meter
    import speed_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             reed_i,
    output logic [WIDTH-1:0] period_o,
    output logic             stopped_o
);

    localparam logic [WIDTH-1:0] TO = WIDTH'(TIMEOUT);

    logic             reed_q;
    logic             edge_w;
    logic             capture_w;
    logic             timeout_w;
    logic             rev_ok_w;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             stopped_q, stopped_d;

    assign edge_w    = reed_i & ~reed_q;
    // armed_q marks that the current count started at a real edge, so the
    // next edge closes a full revolution worth measuring.
    assign capture_w = edge_w & armed_q;

    always_comb begin
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        stopped_d = stopped_q;
        timeout_w = 1'b0;
        if (edge_w) begin
            cnt_d   = '0;
            armed_d = 1'b1;
            if (capture_w && rev_ok_w)
                stopped_d = 1'b0;
        end else begin
            if (en_i && (cnt_q < TO))
                cnt_d = cnt_q + 1'b1;
            // Holding at TIMEOUT keeps re-asserting the stop condition.
            if (cnt_d == TO) begin
                timeout_w = 1'b1;
                stopped_d = 1'b1;
                armed_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reed_q    <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            stopped_q <= 1'b1;
        end else begin
            reed_q    <= reed_i;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            stopped_q <= stopped_d;
        end
    end

    assign stopped_o = stopped_q;

`ifdef SPEED_AVG4_EN
    logic [3:0][WIDTH-1:0] fifo_q;
    logic [2:0]            fill_q;
    logic [WIDTH+1:0]      sum_q;

    // The fourth collected period is the one that clears stopped.
    assign rev_ok_w = (fill_q >= 3'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else if (timeout_w) begin
            fifo_q <= '0;
            fill_q <= '0;
            sum_q  <= '0;
        end else if (capture_w) begin
            fifo_q <= {fifo_q[2:0], cnt_q};
            // Running sum: add the newest, drop the one shifted out.
            sum_q  <= sum_q + {2'b00, cnt_q} - {2'b00, fifo_q[3]};
            if (fill_q != 3'd4)
                fill_q <= fill_q + 3'd1;
        end
    end

    assign period_o = sum_q[WIDTH+1:2];
`else
    logic [WIDTH-1:0] period_q;

    assign rev_ok_w = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_q <= '0;
        else if (capture_w)
            period_q <= cnt_q;
    end

    assign period_o = period_q;
`endif

endmodule

// File: rtl/speed_unit.sv
// speed_unit: wheel speed computation between the reed sensor and the
// display/mode controller, using a shared sequential divider.
//   clk, rst            - system clock, asynchronous active-high reset
//   en                  - timebase tick enable
//   reed                - synchronised reed contact level
//   circ                - wheel circumference
//   start               - one-cycle speed request
//   div_busy/div_ready  - divider status, div_ready is a one-cycle pulse
//   div_res             - divider quotient
//   div_start           - one-cycle divider launch pulse
//   dividend/divisor    - divider operands, held after launch
//   speed               - latest computed speed (saturated at MAX_SPEED)
//   valid               - speed belongs to the latest accepted request
//   stopped             - wheel stopped or no full revolution yet
// Build option SPEED_AVG4_EN selects a 4-period averaged divisor.
module speed_unit
    import speed_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          SPEED_W   = 7,
    parameter int          CIRC_W    = 8,
    parameter logic [15:0] CONST     = DEF_CONST,
    parameter int          FRAC      = DEF_FRAC,
    parameter int          MAX_SPEED = DEF_MAX_SPEED,
    parameter int          TIMEOUT   = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               reed,
    input  logic [CIRC_W-1:0]  circ,
    input  logic               start,
    input  logic               div_busy,
    input  logic               div_ready,
    input  logic [WIDTH-1:0]   div_res,
    output logic               div_start,
    output logic [WIDTH-1:0]   dividend,
    output logic [WIDTH-1:0]   divisor,
    output logic [SPEED_W-1:0] speed,
    output logic               valid,
    output logic               stopped
);

    // Extra WIDTH bits of headroom so the shifted product never loses the
    // bits that decide saturation, whatever FRAC/CIRC_W are.
    localparam int               EXT_W = CIRC_W + 16 + WIDTH;
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_SPEED);

    logic [WIDTH-1:0]   period_w;
    logic               stopped_w;
    logic [EXT_W-1:0]   prod_ext;
    logic [EXT_W-1:0]   num_ext;
    logic [WIDTH-1:0]   num_w;
    logic [WIDTH-1:0]   clamp_w;

    state_e             state_q;
    logic               pend_q;
    logic               div_start_q;
    logic [WIDTH-1:0]   dividend_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [SPEED_W-1:0] speed_q;
    logic               valid_q;

    speed_period_meter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_meter (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .reed_i    (reed),
        .period_o  (period_w),
        .stopped_o (stopped_w)
    );

    assign prod_ext = EXT_W'(circ) * EXT_W'(CONST);
    assign num_ext  = prod_ext >> FRAC;
    assign num_w    = (|(num_ext >> WIDTH)) ? '1 : num_ext[WIDTH-1:0];
    assign clamp_w  = (div_res > MAX_W) ? MAX_W : div_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            div_start_q <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            speed_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            // Requests arriving mid-transaction collapse into one pending flag.
            if (start && (state_q != IDLE))
                pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start || pend_q) begin
                        valid_q <= 1'b0;
                        pend_q  <= 1'b0;
                        if (stopped_w)
                            state_q <= SHORT;
                        else if (period_w == '0)
                            state_q <= SAT;
                        else
                            state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!div_busy) begin
                        dividend_q  <= num_w;
                        divisor_q   <= period_w;
                        div_start_q <= 1'b1;
                        state_q     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (div_busy)
                        state_q <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (div_ready) begin
                        speed_q <= SPEED_W'(clamp_w);
                        state_q <= DONE;
                    end
                end
                SHORT: begin
                    speed_q <= '0;
                    state_q <= DONE;
                end
                SAT: begin
                    speed_q <= SPEED_W'(MAX_W);
                    state_q <= DONE;
                end
                DONE: begin
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_start = div_start_q;
    assign dividend  = dividend_q;
    assign divisor   = divisor_q;
    assign speed     = speed_q;
    assign valid     = valid_q;
    assign stopped   = stopped_w;

endmodule
